// File: rtl/sdram_port_arb.sv
`default_nettype none
// sdram_port_arb: two-port round-robin arbiter feeding one SDRAM controller command channel,
// with per-transaction watchdog.  Rev 1.0
module sdram_port_arb #(
    parameter int IAddrWidth    = 22,
    parameter int DataWidth     = 16,
    parameter int TimeoutCycles = 1024
) (
    input  logic                  i_dram_clk,
    input  logic                  i_rst_n,
    input  logic                  i_p0_req,
    input  logic                  i_p1_req,
    input  logic                  i_p0_we,
    input  logic                  i_p1_we,
    input  logic [IAddrWidth-1:0] i_p0_addr,
    input  logic [IAddrWidth-1:0] i_p1_addr,
    input  logic [DataWidth-1:0]  i_p0_wdata,
    input  logic [DataWidth-1:0]  i_p1_wdata,
    output logic                  o_p0_ack,
    output logic                  o_p1_ack,
    output logic                  o_p0_rvalid,
    output logic                  o_p1_rvalid,
    output logic [DataWidth-1:0]  o_p0_rdata,
    output logic [DataWidth-1:0]  o_p1_rdata,
    output logic                  o_wr_req,
    output logic                  o_rd_req,
    output logic [IAddrWidth-1:0] o_wr_addr,
    output logic [IAddrWidth-1:0] o_rd_addr,
    output logic [DataWidth-1:0]  o_wr_data,
    input  logic                  i_cmd_accept,
    input  logic                  i_cmd_done,
    input  logic [DataWidth-1:0]  i_rd_data,
    input  logic                  i_rd_rdy,
    output logic                  o_err
);
    localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t                state;
    logic                  last_grant;
    logic                  owner;
    logic                  owner_we;
    logic [CntWidth-1:0]   wd_cnt;

    logic                  grant_port;
    logic                  sel_we;
    logic [IAddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0]  sel_wdata;
    logic                  in_txn;
    logic                  finishing;
    logic                  expire;
    logic                  rd_capture;

    always_comb begin
        grant_port = (i_p0_req && i_p1_req) ? ~last_grant : i_p1_req;
        sel_we     = grant_port ? i_p1_we    : i_p0_we;
        sel_addr   = grant_port ? i_p1_addr  : i_p0_addr;
        sel_wdata  = grant_port ? i_p1_wdata : i_p0_wdata;
        in_txn     = (state == REQ) || (state == BUSY);
        // done only counts in REQ when accept arrives in the same cycle
        finishing  = i_cmd_done && ((state == BUSY) || ((state == REQ) && i_cmd_accept));
        expire     = in_txn && !finishing && (wd_cnt == CntLast);
        rd_capture = in_txn && !owner_we && i_rd_rdy && !expire;
    end

    always_ff @(posedge i_dram_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            owner_we    <= 1'b0;
            wd_cnt      <= '0;
            o_p0_ack    <= 1'b0;
            o_p1_ack    <= 1'b0;
            o_p0_rvalid <= 1'b0;
            o_p1_rvalid <= 1'b0;
            o_p0_rdata  <= '0;
            o_p1_rdata  <= '0;
            o_wr_req    <= 1'b0;
            o_rd_req    <= 1'b0;
            o_wr_addr   <= '0;
            o_rd_addr   <= '0;
            o_wr_data   <= '0;
            o_err       <= 1'b0;
        end else begin
            o_p0_ack    <= 1'b0;
            o_p1_ack    <= 1'b0;
            o_p0_rvalid <= 1'b0;
            o_p1_rvalid <= 1'b0;
            o_err       <= 1'b0;

            if (rd_capture) begin
                if (owner) begin
                    o_p1_rdata  <= i_rd_data;
                    o_p1_rvalid <= 1'b1;
                end else begin
                    o_p0_rdata  <= i_rd_data;
                    o_p0_rvalid <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (i_p0_req || i_p1_req) begin
                        last_grant <= grant_port;
                        owner      <= grant_port;
                        owner_we   <= sel_we;
                        o_wr_addr  <= sel_addr;
                        o_rd_addr  <= sel_addr;
                        o_wr_data  <= sel_wdata;
                        o_wr_req   <= sel_we;
                        o_rd_req   <= ~sel_we;
                        o_p0_ack   <= ~grant_port;
                        o_p1_ack   <= grant_port;
                        wd_cnt     <= '0;
                        state      <= REQ;
                    end
                end
                REQ, BUSY: begin
                    if (finishing) begin
                        o_wr_req <= 1'b0;
                        o_rd_req <= 1'b0;
                        state    <= IDLE;
                    end else if (expire) begin
                        o_wr_req <= 1'b0;
                        o_rd_req <= 1'b0;
                        o_err    <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if ((state == REQ) && i_cmd_accept) begin
                            o_wr_req <= 1'b0;
                            o_rd_req <= 1'b0;
                            state    <= BUSY;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arb.sv
`default_nettype none
// tb_sdram_port_arb: directed and randomized checks of sdram_port_arb against a
// transaction-level reference model.
module tb_sdram_port_arb;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p1_req, p0_we, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          cmd_accept, cmd_done, rd_rdy;
    logic [DW-1:0] rd_data;

    logic          p0_ack, p1_ack, p0_rvalid, p1_rvalid, wr_req, rd_req, err;
    logic [DW-1:0] p0_rdata, p1_rdata, wr_data;
    logic [AW-1:0] wr_addr, rd_addr;

    logic          l_p0_ack, l_p1_ack, l_p0_rvalid, l_p1_rvalid, l_wr_req, l_rd_req, l_err;
    logic [DW-1:0] l_p0_rdata, l_p1_rdata, l_wr_data;
    logic [AW-1:0] l_wr_addr, l_rd_addr;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sdram_port_arb #(.IAddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
        .i_dram_clk(clk), .i_rst_n(rst_n),
        .i_p0_req(p0_req), .i_p1_req(p1_req), .i_p0_we(p0_we), .i_p1_we(p1_we),
        .i_p0_addr(p0_addr), .i_p1_addr(p1_addr), .i_p0_wdata(p0_wdata), .i_p1_wdata(p1_wdata),
        .o_p0_ack(p0_ack), .o_p1_ack(p1_ack), .o_p0_rvalid(p0_rvalid), .o_p1_rvalid(p1_rvalid),
        .o_p0_rdata(p0_rdata), .o_p1_rdata(p1_rdata), .o_wr_req(wr_req), .o_rd_req(rd_req),
        .o_wr_addr(wr_addr), .o_rd_addr(rd_addr), .o_wr_data(wr_data),
        .i_cmd_accept(cmd_accept), .i_cmd_done(cmd_done), .i_rd_data(rd_data),
        .i_rd_rdy(rd_rdy), .o_err(err)
    );

    // Default watchdog: used where the controller stalls longer than TO cycles.
    sdram_port_arb #(.IAddrWidth(AW), .DataWidth(DW)) dut_long (
        .i_dram_clk(clk), .i_rst_n(rst_n),
        .i_p0_req(p0_req), .i_p1_req(p1_req), .i_p0_we(p0_we), .i_p1_we(p1_we),
        .i_p0_addr(p0_addr), .i_p1_addr(p1_addr), .i_p0_wdata(p0_wdata), .i_p1_wdata(p1_wdata),
        .o_p0_ack(l_p0_ack), .o_p1_ack(l_p1_ack), .o_p0_rvalid(l_p0_rvalid), .o_p1_rvalid(l_p1_rvalid),
        .o_p0_rdata(l_p0_rdata), .o_p1_rdata(l_p1_rdata), .o_wr_req(l_wr_req), .o_rd_req(l_rd_req),
        .o_wr_addr(l_wr_addr), .o_rd_addr(l_rd_addr), .o_wr_data(l_wr_data),
        .i_cmd_accept(cmd_accept), .i_cmd_done(cmd_done), .i_rd_data(rd_data),
        .i_rd_rdy(rd_rdy), .o_err(l_err)
    );

    // Reference model: one outstanding transaction record plus expected outputs.
    bit            m_active, m_port, m_we, m_accepted, m_last;
    int            m_age;
    logic          e_ack0, e_ack1, e_rv0, e_rv1, e_wr_req, e_rd_req, e_err;
    logic [DW-1:0] e_rdata0, e_rdata1, e_wdata;
    logic [AW-1:0] e_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_port = 0; m_we = 0; m_accepted = 0; m_last = 1; m_age = 0;
        e_ack0 = 0; e_ack1 = 0; e_rv0 = 0; e_rv1 = 0; e_wr_req = 0; e_rd_req = 0; e_err = 0;
        e_rdata0 = '0; e_rdata1 = '0; e_wdata = '0; e_addr = '0;
    endtask

    task automatic model_step();
        bit port;
        bit completes;
        bit timed_out;
        e_ack0 = 0; e_ack1 = 0; e_rv0 = 0; e_rv1 = 0; e_err = 0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_active) begin
            if (p0_req || p1_req) begin
                port       = (p0_req && p1_req) ? !m_last : p1_req;
                m_last     = port;
                m_active   = 1;
                m_port     = port;
                m_we       = port ? p1_we : p0_we;
                m_accepted = 0;
                m_age      = 0;
                e_addr     = port ? p1_addr : p0_addr;
                e_wdata    = port ? p1_wdata : p0_wdata;
                e_wr_req   = m_we;
                e_rd_req   = !m_we;
                if (port) e_ack1 = 1; else e_ack0 = 1;
            end
        end else begin
            completes = cmd_done && (m_accepted || cmd_accept);
            timed_out = !completes && (m_age == TO - 1);
            if (rd_rdy && !m_we && !timed_out) begin
                if (m_port) begin e_rv1 = 1; e_rdata1 = rd_data; end
                else        begin e_rv0 = 1; e_rdata0 = rd_data; end
            end
            if (completes || timed_out) begin
                m_active = 0; e_wr_req = 0; e_rd_req = 0; e_err = timed_out;
            end else begin
                if (cmd_accept) begin m_accepted = 1; e_wr_req = 0; e_rd_req = 0; end
                m_age++;
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".p0_ack"},    64'(p0_ack),    64'(e_ack0));
        chk({ph, ".p1_ack"},    64'(p1_ack),    64'(e_ack1));
        chk({ph, ".p0_rvalid"}, 64'(p0_rvalid), 64'(e_rv0));
        chk({ph, ".p1_rvalid"}, 64'(p1_rvalid), 64'(e_rv1));
        chk({ph, ".p0_rdata"},  64'(p0_rdata),  64'(e_rdata0));
        chk({ph, ".p1_rdata"},  64'(p1_rdata),  64'(e_rdata1));
        chk({ph, ".wr_req"},    64'(wr_req),    64'(e_wr_req));
        chk({ph, ".rd_req"},    64'(rd_req),    64'(e_rd_req));
        chk({ph, ".wr_addr"},   64'(wr_addr),   64'(e_addr));
        chk({ph, ".rd_addr"},   64'(rd_addr),   64'(e_addr));
        chk({ph, ".wr_data"},   64'(wr_data),   64'(e_wdata));
        chk({ph, ".err"},       64'(err),       64'(e_err));
    endtask

    task automatic cycle(input string ph);
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic clear_inputs();
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
        cmd_accept = 0; cmd_done = 0; rd_rdy = 0; rd_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        #2;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int ack_cnt;
        int err_at;
        rst_n = 1;
        clear_inputs();
        model_reset();
        #3;

        // Single port-0 write
        do_reset();
        p0_req = 1; p0_we = 1; p0_addr = 22'h00ABC; p0_wdata = 16'h1234;
        cycle("wr_grant");
        chk("wr_ack0", 64'(p0_ack), 64'd1);
        chk("wr_addr", 64'(wr_addr), 64'h00ABC);
        p0_req = 0; p0_addr = '0; p0_wdata = '0;
        cycle("wr_req1");
        cycle("wr_req2");
        cmd_accept = 1; cycle("wr_accept"); cmd_accept = 0;
        chk("wr_req_drop", 64'(wr_req), 64'd0);
        cycle("wr_busy1");
        cycle("wr_busy2");
        cmd_done = 1; cycle("wr_done"); cmd_done = 0;

        // Round-robin between two simultaneous readers
        do_reset();
        p0_req = 1; p1_req = 1; p0_addr = 22'h11111; p1_addr = 22'h22222;
        for (int k = 0; k < 6; k++) begin
            cycle("rr_grant");
            chk("rr_p0_ack", 64'(p0_ack), 64'((k % 2) == 0));
            chk("rr_p1_ack", 64'(p1_ack), 64'((k % 2) == 1));
            cmd_accept = 1; cycle("rr_accept"); cmd_accept = 0;
            cmd_done = 1; rd_rdy = 1; rd_data = ((k % 2) == 1) ? 16'hCAFE : 16'hBEEF;
            cycle("rr_data");
            cmd_done = 0; rd_rdy = 0;
            if ((k % 2) == 1) chk("rr_p1_rdata", 64'(p1_rdata), 64'hCAFE);
            else              chk("rr_p0_rdata", 64'(p0_rdata), 64'hBEEF);
        end
        p0_req = 0; p1_req = 0;

        // Long controller stall on a port-1 read (default watchdog instance)
        do_reset();
        p1_req = 1; p1_we = 0; p1_addr = 22'h155AA;
        cycle("stall_grant");
        chk("stall_l_ack", 64'(l_p1_ack), 64'd1);
        p1_req = 0;
        ack_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle("stall_hold");
            chk("stall_l_rd_req", 64'(l_rd_req), 64'd1);
            chk("stall_l_wr_req", 64'(l_wr_req), 64'd0);
            ack_cnt += int'(l_p0_ack) + int'(l_p1_ack);
        end
        chk("stall_no_dup_ack", 64'(ack_cnt), 64'd0);
        cmd_accept = 1; cycle("stall_accept"); cmd_accept = 0;
        chk("stall_l_rd_drop", 64'(l_rd_req), 64'd0);
        cmd_done = 1; rd_rdy = 1; rd_data = 16'h1357;
        cycle("stall_done");
        cmd_done = 0; rd_rdy = 0;
        chk("stall_l_rvalid", 64'(l_p1_rvalid), 64'd1);
        chk("stall_l_rdata", 64'(l_p1_rdata), 64'h1357);

        // Watchdog expiry with a port-0 request waiting
        do_reset();
        p1_req = 1; p1_we = 0; p1_addr = 22'h0F0F0;
        cycle("wd_grant");
        p1_req = 0; p0_req = 1; p0_we = 1; p0_addr = 22'h3AAAA; p0_wdata = 16'h0F0F;
        err_at = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle("wd_wait");
            if (err === 1'b1) begin err_at = i; break; end
        end
        chk("wd_latency", 64'(err_at), 64'd16);
        cycle("wd_regrant");
        chk("wd_p0_ack", 64'(p0_ack), 64'd1);
        p0_req = 0;
        cmd_accept = 1; cmd_done = 1; cycle("wd_finish"); cmd_accept = 0; cmd_done = 0;

        // Reset during a busy port-0 read
        do_reset();
        p0_req = 1; p0_we = 0; p0_addr = 22'h2C0DE;
        cycle("rb_grant");
        p0_req = 0;
        cmd_accept = 1; cycle("rb_accept"); cmd_accept = 0;
        rst_n = 0;
        #2;
        model_reset();
        check_all("rb_async");
        rd_rdy = 1; rd_data = 16'hDEAD;
        cycle("rb_held");
        rst_n = 1;
        cycle("rb_release");
        chk("rb_no_rvalid", 64'(p0_rvalid), 64'd0);
        rd_rdy = 0;

        // Accept and done together on a read, next grant right after
        do_reset();
        p0_req = 1; p0_we = 0; p0_addr = 22'h01234;
        cycle("ad_grant");
        p0_req = 0; p1_req = 1; p1_we = 1; p1_addr = 22'h3FFFF; p1_wdata = 16'hA5A5;
        cmd_accept = 1; cmd_done = 1; rd_rdy = 1; rd_data = 16'h5A5A;
        cycle("ad_same");
        cmd_accept = 0; cmd_done = 0; rd_rdy = 0;
        chk("ad_rvalid", 64'(p0_rvalid), 64'd1);
        chk("ad_rdata", 64'(p0_rdata), 64'h5A5A);
        cycle("ad_next");
        chk("ad_p1_ack", 64'(p1_ack), 64'd1);
        p1_req = 0;
        cmd_accept = 1; cmd_done = 1; cycle("ad_finish"); cmd_accept = 0; cmd_done = 0;

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            p0_req     = ($urandom_range(0, 2) != 0);
            p1_req     = ($urandom_range(0, 2) != 0);
            p0_we      = $urandom_range(0, 1) == 1;
            p1_we      = $urandom_range(0, 1) == 1;
            p0_addr    = AW'($urandom);
            p1_addr    = AW'($urandom);
            p0_wdata   = DW'($urandom);
            p1_wdata   = DW'($urandom);
            cmd_accept = ($urandom_range(0, 3) == 0);
            cmd_done   = ($urandom_range(0, 4) == 0);
            rd_rdy     = ($urandom_range(0, 2) == 0);
            rd_data    = DW'($urandom);
            cycle("rand");
            chk("rand_req_excl", 64'(wr_req & rd_req), 64'd0);
            chk("rand_ack_excl", 64'(p0_ack & p1_ack), 64'd0);
        end
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 SHALL have parameter IAddrWidth, default 22, meaning user address width {bank, col, row}.
REQ-002 SHALL have parameter DataWidth, default 16, meaning data word width.
REQ-003 SHALL have parameter TimeoutCycles, default 1024, meaning the watchdog limit per transaction, in clocks.
REQ-004 SHALL have port i_dram_clk  in  1  sole clock; every register SHALL be clocked on its rising edge.
REQ-005 SHALL have port i_rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports i_p0_req / i_p1_req  in  1  each; requester N wants a transaction.
REQ-007 SHALL have ports i_p0_we / i_p1_we  in  1  each; 1 = write, 0 = read.
REQ-008 SHALL have ports i_p0_addr / i_p1_addr  in  IAddrWidth  each; requester address.
REQ-009 SHALL have ports i_p0_wdata / i_p1_wdata  in  DataWidth  each; requester write data.
REQ-010 SHALL have ports o_p0_ack / o_p1_ack  out  1  each; 1-cycle pulse when the request is latched.
REQ-011 SHALL have ports o_p0_rvalid / o_p1_rvalid  out  1  each; 1-cycle pulse, read data valid.
REQ-012 SHALL have ports o_p0_rdata / o_p1_rdata  out  DataWidth  each; registered read data.
REQ-013 SHALL have ports o_wr_req and o_rd_req  out  1  each; command requests to the SDRAM controller.
REQ-014 SHALL have ports o_wr_addr and o_rd_addr  out  IAddrWidth  each; both driven with the latched address.
REQ-015 SHALL have port o_wr_data  out  DataWidth  latched write data.
REQ-016 SHALL have port i_cmd_accept  in  1  controller pulse: command taken (ACT issued).
REQ-017 SHALL have port i_cmd_done  in  1  controller pulse: command complete, controller back in its ready state.
REQ-018 SHALL have port i_rd_data  in  DataWidth  controller read data.
REQ-019 SHALL have port i_rd_rdy  in  1  controller pulse: i_rd_data valid.
REQ-020 SHALL have port o_err  out  1  1-cycle pulse on watchdog expiry.

Function
REQ-021 SHALL implement FSM states IDLE, REQ and BUSY; every output SHALL be registered.
REQ-022 IDLE: if any i_pN_req=1, grant one port by round-robin. At the next edge: latch the granted port's we/addr/wdata and port id, pulse o_pN_ack, assert o_wr_req (we=1) or o_rd_req (we=0), and move to REQ.
REQ-023 Round-robin: a pointer holds the last granted port. When both ports request, the port not last granted wins. A lone requester always wins. The pointer updates on every grant.
REQ-024 REQ: hold the command request high until i_cmd_accept=1, then deassert it at that edge and move to BUSY; a refresh in the controller only delays accept.
REQ-025 BUSY: on i_cmd_done=1, move to IDLE; the next grant is possible at the edge after the return to IDLE.
REQ-026 i_cmd_accept and i_cmd_done high together in REQ: the transaction SHALL complete and the FSM SHALL go directly to IDLE.
REQ-027 i_rd_rdy=1 during a read transaction (REQ or BUSY): capture i_rd_data into the owner's o_pN_rdata and pulse its o_pN_rvalid at the next edge.
REQ-028 i_rd_rdy during a write, or in IDLE, SHALL be ignored, and so SHALL i_cmd_accept/i_cmd_done outside REQ/BUSY.
REQ-029 Watchdog: a counter is cleared on entry to REQ and increments in REQ/BUSY. When it reaches TimeoutCycles-1: drop the command request, pulse o_err, return to IDLE, and give no rvalid.
REQ-030 Latched addr/data SHALL remain stable from grant until the return to IDLE; requester inputs may change after ack.
REQ-031 At most one of o_wr_req/o_rd_req SHALL be high in any cycle, and at most one o_pN_ack in any cycle.

Reset
REQ-032 i_rst_n=0 SHALL immediately force the state to IDLE and the RR pointer to 1, so port 0 wins the first contention.
REQ-033 i_rst_n=0 SHALL immediately clear the watchdog counter and all outputs: req, ack, rvalid and err = 0; rdata, addr and wr_data = 0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no ack, rvalid or err afterwards.
REQ-035 Release of reset SHALL be synchronous to i_dram_clk; the first grant is possible on the first edge after release.

Verification
REQ-036 p0 write only, addr 0x00ABC, data 0x1234; accept at clock 3, done at clock 6 -> o_p0_ack 1 cycle; o_wr_req high from clock 1 to 3 with o_wr_addr=0x00ABC and o_wr_data=0x1234; no o_rd_req.
REQ-037 p0 and p1 reads requested together after reset, repeated -> p0 granted first, then p1, then p0; each o_pN_rvalid carries the i_rd_data supplied (e.g. 0xBEEF to p0, 0xCAFE to p1).
REQ-038 p1 read; i_cmd_accept withheld 40 cycles (simulated refresh) -> o_rd_req held high all 40 cycles, single o_p1_ack, no duplicate request.
REQ-039 TimeoutCycles=16, no i_cmd_accept -> o_err pulses 16 cycles after REQ entry; FSM returns to IDLE; a pending p0 request is granted next.
REQ-040 i_rst_n asserted while in BUSY of a p0 read, then i_rd_rdy pulses -> all outputs 0 immediately and no o_p0_rvalid.
REQ-041 Read with accept and done in the same cycle, plus i_rd_rdy with data 0x5A5A -> direct return to IDLE, o_pN_rvalid with 0x5A5A, and a new grant on the following cycle.
